// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU opcodes, MIPS opcode/funct encodings, flag indices
// and the payload structs carried by the issue and write-back stages.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_REG_W  = 5;
  localparam int unsigned ALU_OPC_W  = 6;
  localparam int unsigned FLAG_W     = 4;

  typedef enum logic [ALU_OPC_W-1:0] {
    ALU_ADD  = 6'b000000,
    ALU_SUB  = 6'b000001,
    ALU_AND  = 6'b000010,
    ALU_OR   = 6'b000011,
    ALU_XOR  = 6'b000100,
    ALU_ADDU = 6'b000101,
    ALU_SLL  = 6'b000110,
    ALU_SRL  = 6'b000111,
    ALU_ADDI = 6'b001000,
    ALU_NOR  = 6'b001001,
    ALU_SLT  = 6'b001010,
    ALU_SLTU = 6'b001011,
    ALU_SRA  = 6'b001100,
    ALU_SUBU = 6'b001101
  } alu_op_e;

  // MIPS primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // MIPS R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    alu_op_e                 op;
    logic [ALU_DATA_W-1:0]   a;
    logic [ALU_DATA_W-1:0]   b;
    logic [ALU_REG_W-1:0]    dest;
    logic                    illegal;
    logic                    trap_en;
  } issue_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0]   data;
    logic [ALU_REG_W-1:0]    dest;
    logic                    we;
    logic [FLAG_W-1:0]       flags;
    logic                    illegal;
    logic                    ovf_trap;
  } wb_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational MIPS ALU-instruction decoder: maps an instruction word and its
// register operands to an ALU opcode, operands, destination and status bits.
module alu_instr_decode
  import alu_pkg::*;
(
  input  logic [ALU_DATA_W-1:0] instr,
  input  logic [ALU_DATA_W-1:0] rs_data,
  input  logic [ALU_DATA_W-1:0] rt_data,
  output alu_op_e               opcode_c,
  output logic [ALU_DATA_W-1:0] a_c,
  output logic [ALU_DATA_W-1:0] b_c,
  output logic [ALU_REG_W-1:0]  dest_c,
  output logic                  illegal_c,
  output logic                  trap_en_c
);

  logic [5:0]            op;
  logic [5:0]            fn;
  logic [ALU_REG_W-1:0]  rt_idx;
  logic [ALU_REG_W-1:0]  rd_idx;
  logic [4:0]            shamt;
  logic [15:0]           imm;
  logic [ALU_DATA_W-1:0] imm_sx;
  logic [ALU_DATA_W-1:0] imm_zx;
  logic                  unused_rs_idx;

  assign op            = instr[31:26];
  assign fn            = instr[5:0];
  assign rt_idx        = instr[20:16];
  assign rd_idx        = instr[15:11];
  assign shamt         = instr[10:6];
  assign imm           = instr[15:0];
  assign imm_sx        = {{16{imm[15]}}, imm};
  assign imm_zx        = {16'h0000, imm};
  // The rs index is resolved upstream; only its data arrives here.
  assign unused_rs_idx = ^instr[25:21];

  always_comb begin
    opcode_c  = ALU_ADD;
    a_c       = '0;
    b_c       = '0;
    dest_c    = '0;
    illegal_c = 1'b0;
    trap_en_c = 1'b0;
    if (op == OP_RTYPE) begin
      dest_c = rd_idx;
      a_c    = rs_data;
      b_c    = rt_data;
      case (fn)
        FN_ADD:  begin opcode_c = ALU_ADD; trap_en_c = 1'b1; end
        FN_ADDU: opcode_c = ALU_ADDU;
        FN_SUB:  begin opcode_c = ALU_SUB; trap_en_c = 1'b1; end
        FN_SUBU: opcode_c = ALU_SUBU;
        FN_AND:  opcode_c = ALU_AND;
        FN_OR:   opcode_c = ALU_OR;
        FN_XOR:  opcode_c = ALU_XOR;
        FN_NOR:  opcode_c = ALU_NOR;
        FN_SLT:  opcode_c = ALU_SLT;
        FN_SLTU: opcode_c = ALU_SLTU;
        FN_SLL:  begin opcode_c = ALU_SLL; a_c = rt_data; b_c = ALU_DATA_W'(shamt); end
        FN_SRL:  begin opcode_c = ALU_SRL; a_c = rt_data; b_c = ALU_DATA_W'(shamt); end
        FN_SRA:  begin opcode_c = ALU_SRA; a_c = rt_data; b_c = ALU_DATA_W'(shamt); end
        FN_SLLV: begin opcode_c = ALU_SLL; a_c = rt_data; b_c = ALU_DATA_W'(rs_data[4:0]); end
        FN_SRLV: begin opcode_c = ALU_SRL; a_c = rt_data; b_c = ALU_DATA_W'(rs_data[4:0]); end
        FN_SRAV: begin opcode_c = ALU_SRA; a_c = rt_data; b_c = ALU_DATA_W'(rs_data[4:0]); end
        default: begin illegal_c = 1'b1; dest_c = '0; a_c = '0; b_c = '0; end
      endcase
    end else begin
      dest_c = rt_idx;
      a_c    = rs_data;
      case (op)
        OP_ADDI:  begin opcode_c = ALU_ADDI; b_c = imm_sx; trap_en_c = 1'b1; end
        OP_ADDIU: begin opcode_c = ALU_ADDU; b_c = imm_sx; end
        OP_SLTI:  begin opcode_c = ALU_SLT;  b_c = imm_sx; end
        OP_SLTIU: begin opcode_c = ALU_SLTU; b_c = imm_sx; end
        OP_ANDI:  begin opcode_c = ALU_AND;  b_c = imm_zx; end
        OP_ORI:   begin opcode_c = ALU_OR;   b_c = imm_zx; end
        OP_XORI:  begin opcode_c = ALU_XOR;  b_c = imm_zx; end
        // LUI rides on the ALU as 0 | (imm << 16)
        OP_LUI:   begin opcode_c = ALU_OR; a_c = '0; b_c = {imm, 16'h0000}; end
        default:  begin illegal_c = 1'b1; dest_c = '0; a_c = '0; b_c = '0; end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ALU front end: decode/issue register feeding the external ALU,
// then a write-back register capturing result and flags for the register file.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned REG_W  = ALU_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [5:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_reg,
  output logic              wb_we,
  output logic [3:0]        wb_flags,
  output logic              wb_illegal,
  output logic              wb_ovf_trap
);

  alu_op_e             dec_op_c;
  logic [DATA_W-1:0]   dec_a_c;
  logic [DATA_W-1:0]   dec_b_c;
  logic [REG_W-1:0]    dec_dest_c;
  logic                dec_illegal_c;
  logic                dec_trap_en_c;

  issue_t              s1_q, s1_d;
  logic                s1_valid_q, s1_valid_d;
  wb_t                 s2_q, s2_d;
  logic                s2_valid_q, s2_valid_d;

  logic                s2_free_c;
  logic                s1_adv_c;
  logic                accept_c;
  logic                trap_c;
  logic [FLAG_W-1:0]   flags_c;

  alu_instr_decode u_decode (
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .opcode_c  (dec_op_c),
    .a_c       (dec_a_c),
    .b_c       (dec_b_c),
    .dest_c    (dec_dest_c),
    .illegal_c (dec_illegal_c),
    .trap_en_c (dec_trap_en_c)
  );

  // Handshakes and next-state for both stages; flush wins over everything.
  always_comb begin
    s2_free_c   = !s2_valid_q || wb_ready;
    s1_adv_c    = s1_valid_q && s2_free_c;
    instr_ready = !flush && (!s1_valid_q || s2_free_c);
    accept_c    = instr_valid && instr_ready;

    flags_c         = '0;
    flags_c[FLAG_N] = alu_n;
    flags_c[FLAG_Z] = alu_z;
    flags_c[FLAG_C] = alu_c;
    flags_c[FLAG_V] = alu_v;
    trap_c          = s1_q.trap_en && alu_v;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;

    if (accept_c) begin
      s1_valid_d   = 1'b1;
      s1_d.op      = dec_op_c;
      s1_d.a       = dec_a_c;
      s1_d.b       = dec_b_c;
      s1_d.dest    = dec_dest_c;
      s1_d.illegal = dec_illegal_c;
      s1_d.trap_en = dec_trap_en_c;
    end else if (s1_adv_c) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv_c && !flush) begin
      s2_valid_d    = 1'b1;
      s2_d.data     = alu_out;
      s2_d.dest     = s1_q.dest;
      s2_d.we       = !s1_q.illegal && !trap_c && (s1_q.dest != '0);
      s2_d.flags    = flags_c;
      s2_d.illegal  = s1_q.illegal;
      s2_d.ovf_trap = trap_c;
    end else if (s2_free_c) begin
      s2_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  assign alu_opcode  = s1_q.op;
  assign alu_a       = s1_q.a;
  assign alu_b       = s1_q.b;
  assign wb_valid    = s2_valid_q;
  assign wb_data     = s2_q.data;
  assign wb_reg      = s2_q.dest;
  assign wb_we       = s2_q.we;
  assign wb_flags    = s2_q.flags;
  assign wb_illegal  = s2_q.illegal;
  assign wb_ovf_trap = s2_q.ovf_trap;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU driving the DUT, MIPS-level
// reference results in a scoreboard, directed cases then randomized traffic.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_we;
  logic [3:0]  wb_flags;
  logic        wb_illegal;
  logic        wb_ovf_trap;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_we(wb_we), .wb_flags(wb_flags), .wb_illegal(wb_illegal), .wb_ovf_trap(wb_ovf_trap)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU; C is carry-out of a + b or a + ~b + 1.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_opcode)
      ALU_ADD, ALU_ADDI, ALU_ADDU: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_SUB, ALU_SUBU: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_out = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_NOR:  alu_out = ~(alu_a | alu_b);
      ALU_SLT:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      ALU_SLL:  alu_out = alu_a << alu_b[4:0];
      ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
      default:  alu_out = '0;
    endcase
    alu_n = alu_out[31];
    alu_z = (alu_out == 32'd0);
  end

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        we;
    logic [3:0]  flags;
    logic        ill;
    logic        trap;
  } exp_t;

  exp_t        sb[$];
  logic        m_s1, m_s2;
  int          checks   = 0;
  int          failures = 0;
  int unsigned acc_cnt  = 0;

  logic [5:0] rfn [16] = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                           FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV};
  logic [5:0] iop [8]  = '{OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural result of one MIPS ALU instruction, straight from its definition.
  function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt);
    exp_t        e;
    logic [31:0] r, sx, zx;
    logic [5:0]  op, fn;
    logic [4:0]  sh, dest;
    logic        c, v, ill, can_trap;
    op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0; can_trap = 1'b0;
    if (op == OP_RTYPE) begin
      dest = ins[15:11];
      case (fn)
        FN_ADD, FN_ADDU: begin
          {c, r} = {1'b0, rs} + {1'b0, rt};
          v = (rs[31] == rt[31]) && (r[31] != rs[31]);
          can_trap = (fn == FN_ADD);
        end
        FN_SUB, FN_SUBU: begin
          {c, r} = {1'b0, rs} + {1'b0, ~rt} + 33'd1;
          v = (rs[31] != rt[31]) && (r[31] != rs[31]);
          can_trap = (fn == FN_SUB);
        end
        FN_AND:  r = rs & rt;
        FN_OR:   r = rs | rt;
        FN_XOR:  r = rs ^ rt;
        FN_NOR:  r = ~(rs | rt);
        FN_SLT:  r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        FN_SLTU: r = (rs < rt) ? 32'd1 : 32'd0;
        FN_SLL:  r = rt << sh;
        FN_SRL:  r = rt >> sh;
        FN_SRA:  r = 32'($signed(rt) >>> sh);
        FN_SLLV: r = rt << rs[4:0];
        FN_SRLV: r = rt >> rs[4:0];
        FN_SRAV: r = 32'($signed(rt) >>> rs[4:0]);
        default: ill = 1'b1;
      endcase
    end else begin
      dest = ins[20:16];
      case (op)
        OP_ADDI, OP_ADDIU: begin
          {c, r} = {1'b0, rs} + {1'b0, sx};
          v = (rs[31] == sx[31]) && (r[31] != rs[31]);
          can_trap = (op == OP_ADDI);
        end
        OP_SLTI:  r = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0;
        OP_SLTIU: r = (rs < sx) ? 32'd1 : 32'd0;
        OP_ANDI:  r = rs & zx;
        OP_ORI:   r = rs | zx;
        OP_XORI:  r = rs ^ zx;
        OP_LUI:   r = {ins[15:0], 16'h0000};
        default:  ill = 1'b1;
      endcase
    end
    if (ill) begin r = '0; c = 1'b0; v = 1'b0; end
    e.data  = r;
    e.dest  = dest;
    e.ill   = ill;
    e.trap  = can_trap && v;
    e.flags = {r[31], (r == 32'd0), c, v};
    e.we    = !ill && !e.trap && (dest != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 5)
      return rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rfn[$urandom_range(0, 15)]);
    else if (k < 9)
      return itype(iop[$urandom_range(0, 7)], 5'($urandom), 5'($urandom), 16'($urandom));
    return 32'($urandom);
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] rsd,
                      input logic [31:0] rtd, input logic wr, input logic fl);
    logic exp_ready, acc, adv;
    exp_t e;
    instr_valid = v; instr = ins; rs_data = rsd; rt_data = rtd; wb_ready = wr; flush = fl;
    #1;
    exp_ready = !fl && (!m_s1 || !m_s2 || wr);
    chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
    chk("wb_valid", 32'(wb_valid), 32'(m_s2));
    if (m_s2) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("wb_data", wb_data, e.data);
        if (!e.ill) chk("wb_reg", 32'(wb_reg), 32'(e.dest));
        chk("wb_we", 32'(wb_we), 32'(e.we));
        chk("wb_flags", 32'(wb_flags), 32'(e.flags));
        chk("wb_illegal", 32'(wb_illegal), 32'(e.ill));
        chk("wb_ovf_trap", 32'(wb_ovf_trap), 32'(e.trap));
      end
    end
    acc = v && exp_ready;
    if (v && instr_ready) acc_cnt++;
    if (m_s2 && wr && sb.size() != 0) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (acc) sb.push_back(ref_exec(ins, rsd, rtd));
    adv  = m_s1 && (!m_s2 || wr);
    m_s2 = !fl && (adv || (m_s2 && !wr));
    m_s1 = !fl && (acc || (m_s1 && !adv));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  logic [31:0] bp_ins [6];
  int unsigned idx, prev;

  initial begin
    rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; instr = '0;
    rs_data = '0; rt_data = '0; wb_ready = 1'b1;
    m_s1 = 1'b0; m_s2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_flags", 32'(wb_flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD r3,r1,r2
    tick(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD), 32'd6, 32'd10, 1'b1, 1'b0);
    chk("add_opc", 32'(alu_opcode), 32'(ALU_ADD));
    chk("add_a", alu_a, 32'd6);
    chk("add_b", alu_b, 32'd10);
    idle();
    chk("add_wb_data", wb_data, 32'd16);
    chk("add_wb_reg", 32'(wb_reg), 32'd3);
    chk("add_wb_we", 32'(wb_we), 32'd1);
    chk("add_flags", 32'(wb_flags), 32'h0);

    // ADDI r4,r1,0xFFFF
    tick(1'b1, itype(OP_ADDI, 5'd1, 5'd4, 16'hFFFF), 32'd1, 32'd0, 1'b1, 1'b0);
    chk("addi_opc", 32'(alu_opcode), 32'(ALU_ADDI));
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    idle();
    chk("addi_wb_data", wb_data, 32'd0);
    chk("addi_flags", 32'(wb_flags), 32'b0110);
    chk("addi_wb_we", 32'(wb_we), 32'd1);

    // Signed overflow traps on ADD, not on ADDU
    tick(1'b1, rtype(5'd1, 5'd2, 5'd7, 5'd0, FN_ADD), 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
    tick(1'b1, rtype(5'd1, 5'd2, 5'd7, 5'd0, FN_ADDU), 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
    chk("ovf_trap", 32'(wb_ovf_trap), 32'd1);
    chk("ovf_we", 32'(wb_we), 32'd0);
    idle();
    chk("addu_trap", 32'(wb_ovf_trap), 32'd0);
    chk("addu_we", 32'(wb_we), 32'd1);
    chk("addu_data", wb_data, 32'h8000_0000);

    // SLL r5,r2,4 then LUI r6,0x1234
    tick(1'b1, rtype(5'd0, 5'd2, 5'd5, 5'd4, FN_SLL), 32'd99, 32'd3, 1'b1, 1'b0);
    chk("sll_opc", 32'(alu_opcode), 32'(ALU_SLL));
    chk("sll_a", alu_a, 32'd3);
    chk("sll_b", alu_b, 32'd4);
    tick(1'b1, itype(OP_LUI, 5'd0, 5'd6, 16'h1234), 32'h5555_5555, 32'd0, 1'b1, 1'b0);
    chk("lui_opc", 32'(alu_opcode), 32'(ALU_OR));
    chk("lui_a", alu_a, 32'd0);
    chk("lui_b", alu_b, 32'h1234_0000);
    idle();
    chk("lui_data", wb_data, 32'h1234_0000);
    idle();

    // Back-to-back stream with write-back stalled for three cycles
    for (int i = 0; i < 6; i++) bp_ins[i] = rtype(5'd1, 5'd2, 5'(8 + i), 5'd0, FN_ADDU);
    idx = 0; acc_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 3) chk("bp_accepts_in_stall", acc_cnt, 32'd2);
      prev = acc_cnt;
      tick(idx < 5, bp_ins[idx], 32'(idx + 1) << 12, 32'(idx), cyc >= 3, 1'b0);
      if (acc_cnt != prev) idx++;
    end
    chk("bp_all_accepted", idx, 32'd5);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Undecodable opcode 0x3F
    tick(1'b1, itype(6'h3F, 5'd1, 5'd9, 16'h1234), 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
    chk("ill_opc", 32'(alu_opcode), 32'(ALU_ADD));
    chk("ill_a", alu_a, 32'd0);
    chk("ill_b", alu_b, 32'd0);
    idle();
    chk("ill_flag", 32'(wb_illegal), 32'd1);
    chk("ill_we", 32'(wb_we), 32'd0);

    // Flush with an entry in stage 1 and a new instruction offered
    tick(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_OR), 32'hF0, 32'h0F, 1'b1, 1'b0);
    tick(1'b1, rtype(5'd1, 5'd2, 5'd4, 5'd0, FN_AND), 32'hFF, 32'h0F, 1'b1, 1'b1);
    chk("flush_wb_valid", 32'(wb_valid), 32'd0);
    idle();

    // Randomized traffic with backpressure and occasional flush
    for (int n = 0; n < 400; n++)
      tick($urandom_range(0, 9) < 7, rand_instr(), rand_data(), rand_data(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
    repeat (3) idle();

    // Asynchronous reset with both stages full
    tick(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_SUB), 32'd50, 32'd8, 1'b0, 1'b0);
    tick(1'b1, rtype(5'd1, 5'd2, 5'd4, 5'd0, FN_XOR), 32'd5, 32'd3, 1'b0, 1'b0);
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    sb.delete(); m_s1 = 1'b0; m_s2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
